// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Purpose:
//   Resolves three front-end hazards with fixed priority:
//     1. taken branch/jump in EX  -> flush IF/ID, bubble ID/EX, no stall
//     2. load-use on rs/rt        -> one-cycle freeze of PC and IF/ID, bubble ID/EX
//     3. mult/div issue           -> MD_LATENCY cycles of freeze after the issue cycle
//   All outputs are a Mealy decode of the registered state and the current inputs.
//
// Optional feature:
//   HAZARD_PERF_CNT_EN - when defined, a 16-bit saturating stall-cycle counter is
//   built and driven on stall_cnt_o. When undefined, stall_cnt_o is tied to zero.
//
// Parameters:
//   MD_LATENCY      stall cycles inserted after a mult/div issues (1..16)
//   REG_W           register-specifier width
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-low reset
//   id_rs_i         rs field of the instruction in ID
//   id_rt_i         rt field of the instruction in ID
//   id_uses_rt_i    ID instruction reads rt as a source
//   id_md_start_i   ID instruction is mult/multu/div/divu
//   idex_memread_i  instruction in EX is a load
//   idex_rt_i       destination rt of the instruction in EX
//   branch_taken_i  branch/jump resolved taken in EX this cycle
//   pc_write_o      PC load enable
//   ifid_write_o    IF/ID register write enable
//   if_flush_o      IF/ID register clear
//   idex_bubble_o   zero ID/EX control fields
//   stall_o         front end frozen this cycle
//   stall_cnt_o     stall-cycle performance counter

module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_md_start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             if_flush_o,
    output logic             idex_bubble_o,
    output logic             stall_o,
    output logic [15:0]      stall_cnt_o
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY) + 1;
    // Loaded on issue; MD_BUSY then lasts md_cnt+1 cycles, i.e. MD_LATENCY.
    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LATENCY - 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;

    logic load_use;
    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic idex_bubble;
    logic stall;

    // $zero is never a real producer, so a load to r0 cannot create a hazard.
    assign load_use = idex_memread_i
                    & (idex_rt_i != '0)
                    & ((idex_rt_i == id_rs_i)
                       | (id_uses_rt_i & (idex_rt_i == id_rt_i)));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_RUN: begin
                // A branch squashes the mult/div; a load-use stall holds it in ID
                // so it issues on a later cycle.
                if (!branch_taken_i && !load_use && id_md_start_i) begin
                    state_d  = ST_MD_BUSY;
                    md_cnt_d = MD_RELOAD;
                end
            end
            ST_MD_BUSY: begin
                // EX holds only bubbles here, so no other hazard can arise.
                if (md_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        idex_bubble = 1'b0;
        stall       = 1'b0;
        if (!rst_i) begin
            // Keep the pipeline clean while reset is held.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            if_flush    = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken_i) begin
                        if_flush    = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall       = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall       = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign pc_write_o    = pc_write;
    assign ifid_write_o  = ifid_write;
    assign if_flush_o    = if_flush;
    assign idex_bubble_o = idex_bubble;
    assign stall_o       = stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

    localparam int unsigned MD_LAT = 4;

    // Expected output vectors {pc_write, ifid_write, if_flush, idex_bubble, stall}
    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_BR    = 5'b11110;
    localparam logic [4:0] O_RST   = 5'b00110;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_uses_rt_i;
    logic        id_md_start_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rt_i;
    logic        branch_taken_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        if_flush_o;
    logic        idex_bubble_o;
    logic        stall_o;
    logic [15:0] stall_cnt_o;

    hazard_ctrl #(
        .MD_LATENCY(MD_LAT),
        .REG_W(5)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i),
        .id_md_start_i(id_md_start_i),
        .idex_memread_i(idex_memread_i),
        .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i),
        .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o),
        .if_flush_o(if_flush_o),
        .idex_bubble_o(idex_bubble_o),
        .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       md;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic [4:0] exp;
    } row_t;

    typedef struct packed {
        logic [4:0]  o;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt = 16'h0000;
    int          errors  = 0;
    int          checks  = 0;

    function automatic row_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic md, input logic memread,
                                input logic [4:0] ex_rt, input logic br, input logic [4:0] e);
        row_t r;
        r.rst = rst; r.rs = rs; r.rt = rt; r.uses_rt = uses_rt; r.md = md;
        r.memread = memread; r.ex_rt = ex_rt; r.br = br; r.exp = e;
        return r;
    endfunction

    // Drives one cycle of stimulus away from the rising edge, queues the expected
    // outputs for that cycle, and advances the expected stall counter.
    task automatic drive(input row_t r);
        exp_t e;
        @(negedge clk_i);
        rst_i          = r.rst;
        id_rs_i        = r.rs;
        id_rt_i        = r.rt;
        id_uses_rt_i   = r.uses_rt;
        id_md_start_i  = r.md;
        idex_memread_i = r.memread;
        idex_rt_i      = r.ex_rt;
        branch_taken_i = r.br;
        e.o   = r.exp;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
        if (!r.rst) exp_cnt = 16'h0000;
        else if (r.exp[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        #1;
    endtask

    task automatic run_rows(input string name, input row_t rows[$]);
        exp_t got;
        foreach (rows[i]) begin
            drive(rows[i]);
            got = exp_q.pop_front();
            checks++;
            if ({pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o, stall_o, stall_cnt_o} !== got) begin
                errors++;
                $display("FAIL %s[%0d] got outs=%b cnt=%0d expected outs=%b cnt=%0d", name, i,
                         {pc_write_o, ifid_write_o, if_flush_o, idex_bubble_o, stall_o},
                         stall_cnt_o, got.o, got.cnt);
            end
        end
    endtask

    task automatic test_reset();
        row_t rows[$];
        rows.push_back(mk(0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 1, O_RST));
        rows.push_back(mk(0, 5'd8, 5'd0, 0, 1, 1, 5'd8, 1, O_RST));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd3, 5'd4, 1, 0, 0, 5'd5, 0, O_IDLE));
        run_rows("reset", rows);
    endtask

    task automatic test_load_use();
        row_t rows[$];
        rows.push_back(mk(1, 5'd8, 5'd2, 0, 0, 1, 5'd8, 0, O_STALL));
        rows.push_back(mk(1, 5'd8, 5'd2, 0, 0, 0, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd0, 5'd2, 0, 0, 1, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd7, 5'd2, 1, 0, 1, 5'd8, 0, O_IDLE));
        run_rows("load_use", rows);
    endtask

    task automatic test_rt_dep();
        row_t rows[$];
        rows.push_back(mk(1, 5'd1, 5'd9, 0, 0, 1, 5'd9, 0, O_IDLE));
        rows.push_back(mk(1, 5'd1, 5'd9, 1, 0, 1, 5'd9, 0, O_STALL));
        rows.push_back(mk(1, 5'd1, 5'd9, 1, 0, 0, 5'd0, 0, O_IDLE));
        run_rows("rt_dep", rows);
    endtask

    task automatic test_branch_priority();
        row_t rows[$];
        rows.push_back(mk(1, 5'd8, 5'd0, 0, 1, 1, 5'd8, 1, O_BR));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        run_rows("branch_prio", rows);
    endtask

    task automatic test_mult();
        row_t rows[$];
        logic [15:0] cnt_before;
        cnt_before = exp_cnt;
        rows.push_back(mk(1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 0, O_IDLE));
        // Hazards that would otherwise flush or stall are ignored while busy.
        for (int k = 0; k < int'(MD_LAT); k++)
            rows.push_back(mk(1, 5'd8, 5'd0, 0, 1, 1, 5'd8, (k == 1), O_STALL));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        run_rows("mult", rows);
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (stall_cnt_o !== cnt_before + 16'(MD_LAT)) begin
`else
        if (stall_cnt_o !== 16'h0000) begin
`endif
            errors++;
            $display("FAIL mult_cnt got=%0d before=%0d latency=%0d", stall_cnt_o, cnt_before, MD_LAT);
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        rows.push_back(mk(1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 0, O_IDLE));
        for (int k = 0; k < int'(MD_LAT); k++)
            rows.push_back(mk(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, O_STALL));
        rows.push_back(mk(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, O_IDLE));
        for (int k = 0; k < int'(MD_LAT); k++)
            rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_STALL));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        run_rows("back_to_back", rows);
    endtask

    task automatic test_reset_mid_md();
        row_t rows[$];
        rows.push_back(mk(1, 5'd2, 5'd3, 1, 1, 0, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_STALL));
        rows.push_back(mk(0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 1, O_RST));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        rows.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, O_IDLE));
        run_rows("reset_mid_md", rows);
    endtask

    initial begin
        rst_i          = 1'b0;
        id_rs_i        = '0;
        id_rt_i        = '0;
        id_uses_rt_i   = 1'b0;
        id_md_start_i  = 1'b0;
        idex_memread_i = 1'b0;
        idex_rt_i      = '0;
        branch_taken_i = 1'b0;
        repeat (2) @(posedge clk_i);

        test_reset();
        test_load_use();
        test_rt_dep();
        test_branch_priority();
        test_mult();
        test_back_to_back();
        test_reset_mid_md();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the write-enable and flush inputs of the IF/ID stall register, the PC write-enable, and the ID/EX bubble insert. It resolves three hazards with fixed priority: taken-branch flush, load-use stall, and a multi-cycle mult/div stall. It sits beside the ID stage and reads ID-stage register fields plus ID/EX and EX status.

## Interface
Parameters:
- MD_LATENCY, 4, number of stall cycles inserted after a mult/div issues (legal 1..16)
- REG_W, 5, register-specifier width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- id_rs_i  in  REG_W  rs field of the instruction in ID
- id_rt_i  in  REG_W  rt field of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads rt as a source
- id_md_start_i  in  1  the ID instruction is mult/multu/div/divu
- idex_memread_i  in  1  the instruction in EX is a load
- idex_rt_i  in  REG_W  destination rt of the instruction in EX
- branch_taken_i  in  1  branch/jump resolved taken in EX this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID register write enable
- if_flush_o  out  1  IF/ID register clear
- idex_bubble_o  out  1  zero ID/EX control fields
- stall_o  out  1  pipeline front end frozen this cycle
- stall_cnt_o  out  16  stall-cycle performance counter

## Operation
- State: RUN, MD_BUSY; down-counter md_cnt of width clog2(MD_LATENCY)+1.
- Outputs are a Mealy decode of state and inputs. State and counters are registered.
- load_use = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == id_rs_i) | (id_uses_rt_i & idex_rt_i == id_rt_i)).
- RUN, priority order:
  - branch_taken_i: pc_write=1, ifid_write=1, if_flush=1, idex_bubble=1, stall=0. Stay in RUN. id_md_start_i is ignored because the mult/div is squashed.
  - load_use: pc_write=0, ifid_write=0, if_flush=0, idex_bubble=1, stall=1. Stay in RUN. id_md_start_i is ignored this cycle.
  - id_md_start_i: the mult/div issues normally (pc_write=1, ifid_write=1, others 0). Next state is MD_BUSY with md_cnt = MD_LATENCY-1.
  - Otherwise: pc_write=1, ifid_write=1, if_flush=0, idex_bubble=0, stall=0.
- MD_BUSY:
  - Every cycle drives pc_write=0, ifid_write=0, if_flush=0, idex_bubble=1, stall=1.
  - If md_cnt==0, next state is RUN. Otherwise decrement md_cnt.
  - branch_taken_i, load_use and id_md_start_i are ignored, since EX holds only bubbles.
- stall_cnt_o: increments by 1 on each non-reset cycle with stall_o=1 and saturates at 0xFFFF.

## Timing
- Reset (rst_i=0 at a rising edge): state=RUN, md_cnt=0, stall_cnt_o=0.
- While rst_i=0, outputs are pc_write=0, ifid_write=0, if_flush=1, idex_bubble=1, stall=0.
- Reset in MD_BUSY aborts the stall immediately: RUN on the next cycle.
- Load-use costs exactly 1 stall cycle. Detection clears naturally once the load advances and ID/EX holds a bubble.
- Mult/div: issue cycle N is unstalled. Cycles N+1..N+MD_LATENCY are stalled. Cycle N+MD_LATENCY+1 is back in RUN.
- Taken branch: flush asserts in the same cycle branch_taken_i is high, so there are zero extra stall cycles.
- Simultaneous branch_taken_i and load_use: the branch wins and there is no stall.
- Back-to-back mult/div: the second one sits held in ID during MD_BUSY and issues on the first RUN cycle. It then enters MD_BUSY again with no gap cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: the 16-bit saturating stall counter is built as described.
- HAZARD_PERF_CNT_EN undefined: no counter flops are built and stall_cnt_o is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with branch_taken_i=1 and id_md_start_i=1 → if_flush=1, idex_bubble=1, pc_write=0, stall_cnt_o=0. After release, state is RUN with pc_write=1.
- Load-use: idex_memread_i=1, idex_rt_i=8, id_rs_i=8 for 1 cycle → that cycle pc_write=0, ifid_write=0, idex_bubble=1. The repeat with idex_rt_i=0 produces no stall.
- rt dependence: idex_rt_i=9, id_rt_i=9, id_uses_rt_i=0 → no stall. With id_uses_rt_i=1 → 1 stall cycle.
- Branch priority: branch_taken_i=1 together with load_use=1 and id_md_start_i=1 → if_flush=1, pc_write=1, no MD_BUSY entry, stall_cnt_o unchanged.
- Mult/div with MD_LATENCY=4: id_md_start_i=1 at cycle 10 → stall_o=1 in cycles 11–14, 0 in cycle 15. stall_cnt_o=4 with HAZARD_PERF_CNT_EN, 0 without.
- Reset mid-MD: rst_i=0 in the second MD_BUSY cycle → after release, state is RUN with no residual stall.
